iob_fp_mul_seq: RTL and testbench
=================================

Name: iob_fp_mul_seq

Overview:
- Sequential IEEE-754-style floating-point multiplier, the inverse-operation companion to the floating-point divider in the arith_logic/iob_fp library.
- Latches two operands on start_i and forms the mantissa product with an iterative shift-add datapath at one bit per cycle.
- Normalizes, rounds to nearest-even, packs, and returns the result with a one-cycle done_o pulse.
- Handles special operands (NaN, Inf, zero, subnormal) on a fast path and reports overflow, underflow and invalid.

Parameters:
- DATA_W, 32, total float width.
- EXP_W, 8, exponent width; MAN_W = DATA_W-EXP_W is the mantissa width including the hidden bit; BIAS = 2**(EXP_W-1)-1.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse; samples op_a_i and op_b_i.
- op_a_i  input  DATA_W  operand A.
- op_b_i  input  DATA_W  operand B.
- done_o  output  1  one-cycle pulse; res_o and flags valid.
- res_o  output  DATA_W  packed product.
- overflow_o  output  1  result saturated to Inf.
- underflow_o  output  1  result flushed to zero.
- exception_o  output  1  invalid operation, result is NaN.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Reset asserted mid-operation aborts the operation; no done_o pulse follows.
- FSM states: IDLE, MULT, NORM, ROUND, DONE.
- start_i in any state captures operands and restarts the operation; any in-flight result is discarded.
- Capture: sign = sa^sb; exponent sum = ea+eb-BIAS, held at EXP_W+2 bits signed.
- Capture, special check: if either operand is special, the FSM goes directly to DONE with the special result.
- MULT: 2*MAN_W-bit accumulator with shift-add over multiplier bits, LSB first. Exactly MAN_W cycles, counter 0..MAN_W-1.
- NORM:
  - If product bit 2*MAN_W-1 is set: exponent +1, take the upper MAN_W bits.
  - Otherwise: shift left by 1.
  - Keep guard bit, round bit, and sticky = OR of all remaining lower bits.
- ROUND: round-to-nearest-even. A mantissa carry-out renormalizes (exponent +1).
- Range check after rounding:
  - Exponent >= 2**EXP_W-1: res = Inf(sign), overflow_o=1.
  - Exponent <= 0: res = signed zero, underflow_o=1. No subnormal output.
- DONE: res_o, flags and done_o are registered. done_o is high for exactly one cycle, then the FSM returns to IDLE.
- Latency:
  - Normal path: done_o rises MAN_W+3 rising edges after the edge sampling start_i (27 for FP32).
  - Special path: done_o rises 2 edges after that edge.
- res_o and the flags hold their values until the next done_o. Flags are mutually exclusive.
- Special cases, first match wins:
  - Either operand NaN: canonical NaN {0, all-ones exponent, mantissa MSB 1, rest 0}, exception_o=1.
  - Inf*zero: canonical NaN, exception_o=1.
  - Either operand Inf: Inf(sa^sb).
  - Either operand zero or subnormal: signed zero (sa^sb). Subnormals are treated as zero and no flag is raised.

Decomposition:
- Shared package:
  - Constants: MAN_W, BIAS.
  - Canonical NaN constant and Inf(sign) constant.
  - FSM state encoding, 3-bit.
- Existing iob_fp_special is reused per operand; existing iob_fp_round is reused in ROUND.
- One new sub-module is natural: iob_mul_shiftadd.
  - Generic unsigned iterative multiplier with start/done.
  - Parameter W; product 2W bits; W cycles.
  - Used for the MULT phase.

Test Plan:
- 0x40000000 * 0x40400000 (2.0*3.0) -> res_o=0x40C00000, done_o exactly 27 cycles after start, all flags 0.
- 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> 0x40100000, exercises the product>=2 renormalize path.
- 0x3F800001 * 0x3F800001 -> 0x3F800002, rounding with sticky set.
- 0xC0000000 * 0x3F000000 -> 0xBF800000, sign path.
- Overflow and underflow:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow_o=1.
  - 0x00800000 * 0x00800000 -> 0x00000000, underflow_o=1.
- Special and control:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, exception_o=1, done_o 2 cycles after start.
  - New start_i at cycle 10 of an operation -> only the second result appears, 27 cycles after the second start.
  - arst_n_i low mid-MULT -> outputs 0 and no done_o pulse.

Source files
------------

// File: rtl/iob_fp_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_seq_pkg
// Shared definitions for the sequential floating-point multiplier:
//   - default float format (FP32): data width, exponent width, mantissa width
//     including the hidden bit, and exponent bias
//   - canonical NaN constant and Inf(sign) helper for that format
//   - 3-bit FSM state encoding
// -----------------------------------------------------------------------------
package iob_fp_mul_seq_pkg;

    localparam int FP_DATA_W = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = FP_DATA_W - FP_EXP_W;       // includes hidden bit
    localparam int FP_FRAC_W = FP_MAN_W - 1;               // stored fraction bits
    localparam int FP_BIAS   = 2 ** (FP_EXP_W - 1) - 1;

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
    localparam logic [FP_DATA_W-1:0] FP_CANON_NAN =
        {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_FRAC_W-1){1'b0}}};

    function automatic logic [FP_DATA_W-1:0] fp_inf(input logic sign);
        return {sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/iob_fp_mul_seq_if.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_seq_if
// Operation handshake and result bus of the sequential FP multiplier.
//   start_i      one-cycle pulse, samples op_a_i / op_b_i
//   op_a_i/op_b_i operands
//   done_o       one-cycle pulse, result and flags valid
//   res_o        packed product
//   overflow_o / underflow_o / exception_o  result flags (mutually exclusive)
// slave modport: the multiplier; master modport: the requester.
// -----------------------------------------------------------------------------
interface iob_fp_mul_seq_if
    import iob_fp_mul_seq_pkg::*;
#(
    parameter int DATA_W = FP_DATA_W
) ();

    logic              start_i;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic              done_o;
    logic [DATA_W-1:0] res_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              exception_o;

    modport slave (
        input  start_i, op_a_i, op_b_i,
        output done_o, res_o, overflow_o, underflow_o, exception_o
    );

    modport master (
        output start_i, op_a_i, op_b_i,
        input  done_o, res_o, overflow_o, underflow_o, exception_o
    );

endinterface

// File: rtl/iob_fp_round.sv
// -----------------------------------------------------------------------------
// iob_fp_round
// Round-to-nearest-even of a normalized mantissa.
//   man_i     normalized mantissa including hidden bit
//   guard_i / round_i / sticky_i   bits below the mantissa LSB
//   exp_i     signed biased exponent (EXP_W+2 bits)
//   frac_o    rounded fraction without the hidden bit
//   exp_o     exponent, incremented when rounding carries out
// -----------------------------------------------------------------------------
module iob_fp_round #(
    parameter int MAN_W = 24,
    parameter int EW    = 10
) (
    input  logic [MAN_W-1:0]     man_i,
    input  logic                 guard_i,
    input  logic                 round_i,
    input  logic                 sticky_i,
    input  logic signed [EW-1:0] exp_i,
    output logic [MAN_W-2:0]     frac_o,
    output logic signed [EW-1:0] exp_o
);

    logic             round_up;
    logic [MAN_W:0]   sum;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        // Ties go to the even mantissa: a half-way value rounds up only if LSB is 1.
        round_up = guard_i & (round_i | sticky_i | man_i[0]);
        sum      = {1'b0, man_i} + {{MAN_W{1'b0}}, round_up};
        if (sum[MAN_W]) begin
            // 1.111..1 + ulp = 10.000..0: renormalize, fraction becomes zero.
            frac_o = sum[MAN_W-1:1];
            exp_o  = exp_i + $signed(EW'(1));
        end else begin
            frac_o = sum[MAN_W-2:0];
            exp_o  = exp_i;
        end
    end

endmodule

// File: rtl/iob_fp_special.sv
// -----------------------------------------------------------------------------
// iob_fp_special
// Classifies one packed float operand.
//   op_i       packed operand
//   is_nan_o   exponent all ones, fraction non-zero
//   is_inf_o   exponent all ones, fraction zero
//   is_zero_o  exponent zero (zero or subnormal; subnormals are flushed)
// -----------------------------------------------------------------------------
module iob_fp_special #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic [DATA_W-1:0] op_i,
    output logic              is_nan_o,
    output logic              is_inf_o,
    output logic              is_zero_o
);

    localparam int FRAC_W = DATA_W - EXP_W - 1;

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = op_i[DATA_W-2 -: EXP_W];
    assign frac_f = op_i[FRAC_W-1:0];

    assign is_nan_o  = (&exp_f) && (|frac_f);
    assign is_inf_o  = (&exp_f) && !(|frac_f);
    assign is_zero_o = !(|exp_f);

endmodule

// File: rtl/iob_mul_shiftadd.sv
// -----------------------------------------------------------------------------
// iob_mul_shiftadd
// Generic unsigned iterative multiplier, one multiplier bit per cycle, LSB
// first. Takes exactly W cycles after the start_i edge.
//   start_i   loads a_i / b_i and restarts (also while busy)
//   done_o    high during the last iteration; p_o is final one cycle later
//   p_o       2W-bit product accumulator
// -----------------------------------------------------------------------------
module iob_mul_shiftadd #(
    parameter int W = 24
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] p_o
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     a_q;
    logic [2*W-1:0]   acc_q;     // upper half: partial sum, lower half: multiplier
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [W:0]       sum;

    // Add the multiplicand into the upper half when the current multiplier bit
    // (acc_q[0]) is set; the carry is kept for the following right shift.
    always_comb begin
        sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            a_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            acc_q  <= {{W{1'b0}}, b_i};
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= {sum, acc_q[W-1:1]};
            if (cnt_q == CNT_W'(W - 1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(W - 1));
    assign p_o    = acc_q;

endmodule

// File: rtl/iob_fp_mul_seq.sv
// -----------------------------------------------------------------------------
// iob_fp_mul_seq
// Sequential IEEE-754-style floating-point multiplier.
//   clk_i     clock, rising edge
//   arst_n_i  asynchronous active-low reset (aborts any operation)
//   bus       iob_fp_mul_seq_if.slave: start/operands in, done/result/flags out
// Flow: capture -> MULT (MAN_W shift-add cycles) -> NORM -> ROUND -> DONE.
// Special operands are detected in the first MULT cycle and skip to DONE.
// Latency from the start_i edge: MAN_W+3 edges normal, 2 edges special.
// -----------------------------------------------------------------------------
module iob_fp_mul_seq
    import iob_fp_mul_seq_pkg::*;
#(
    parameter int DATA_W = FP_DATA_W,
    parameter int EXP_W  = FP_EXP_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    iob_fp_mul_seq_if.slave  bus
);

    localparam int MAN_W  = DATA_W - EXP_W;
    localparam int FRAC_W = MAN_W - 1;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int EW     = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S    = '0;
    localparam logic [DATA_W-1:0]    NAN_RES   =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] inf_res(input logic sign);
        return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

    // ---------------- state and datapath registers ----------------
    state_t               state_q, state_d;
    logic [DATA_W-1:0]    op_a_q, op_b_q;
    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [MAN_W-1:0]     man_q;
    logic                 guard_q, round_q, sticky_q;
    logic [DATA_W-1:0]    res_q;
    logic                 ovf_q, unf_q, exc_q;

    // FSM-derived enables
    logic take_special, do_norm, do_round, fire_done;

    // ---------------- capture ----------------
    logic signed [EW-1:0] exp_sum;

    assign exp_sum = $signed({2'b00, bus.op_a_i[DATA_W-2 -: EXP_W]})
                   + $signed({2'b00, bus.op_b_i[DATA_W-2 -: EXP_W]})
                   - BIAS_S;

    // ---------------- special operands ----------------
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic special_any;
    logic [DATA_W-1:0] special_res;
    logic special_exc;

    iob_fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_special_a (
        .op_i      (op_a_q),
        .is_nan_o  (a_nan),
        .is_inf_o  (a_inf),
        .is_zero_o (a_zero)
    );

    iob_fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_special_b (
        .op_i      (op_b_q),
        .is_nan_o  (b_nan),
        .is_inf_o  (b_inf),
        .is_zero_o (b_zero)
    );

    assign special_any = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // First match wins: NaN, Inf*0, Inf, zero/subnormal.
    always_comb begin
        special_res = {sign_q, {(DATA_W-1){1'b0}}};
        special_exc = 1'b0;
        if (a_nan || b_nan) begin
            special_res = NAN_RES;
            special_exc = 1'b1;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            special_res = NAN_RES;
            special_exc = 1'b1;
        end else if (a_inf || b_inf) begin
            special_res = inf_res(sign_q);
        end
    end

    // ---------------- mantissa multiplier ----------------
    // Hidden bit is forced to 1: zero/subnormal operands never reach NORM.
    logic                 mul_done;
    logic [2*MAN_W-1:0]   prod;

    iob_mul_shiftadd #(.W(MAN_W)) u_mul (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .start_i  (bus.start_i),
        .a_i      ({1'b1, bus.op_a_i[FRAC_W-1:0]}),
        .b_i      ({1'b1, bus.op_b_i[FRAC_W-1:0]}),
        .done_o   (mul_done),
        .p_o      (prod)
    );

    // ---------------- normalization ----------------
    // Product of two [1,2) mantissas lies in [1,4): MSB set means >= 2.
    logic [MAN_W-1:0] norm_man;
    logic             norm_g, norm_r, norm_s, norm_inc;

    always_comb begin
        if (prod[2*MAN_W-1]) begin
            norm_man = prod[2*MAN_W-1 -: MAN_W];
            norm_g   = prod[MAN_W-1];
            norm_r   = prod[MAN_W-2];
            norm_s   = |prod[MAN_W-3:0];
            norm_inc = 1'b1;
        end else begin
            norm_man = prod[2*MAN_W-2 -: MAN_W];
            norm_g   = prod[MAN_W-2];
            norm_r   = prod[MAN_W-3];
            norm_s   = |prod[MAN_W-4:0];
            norm_inc = 1'b0;
        end
    end

    // ---------------- rounding and range check ----------------
    logic [FRAC_W-1:0]    rnd_frac;
    logic signed [EW-1:0] rnd_exp;
    logic [DATA_W-1:0]    final_res;
    logic                 final_ovf, final_unf;

    iob_fp_round #(.MAN_W(MAN_W), .EW(EW)) u_round (
        .man_i    (man_q),
        .guard_i  (guard_q),
        .round_i  (round_q),
        .sticky_i (sticky_q),
        .exp_i    (exp_q),
        .frac_o   (rnd_frac),
        .exp_o    (rnd_exp)
    );

    always_comb begin
        final_res = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        final_ovf = 1'b0;
        final_unf = 1'b0;
        if (rnd_exp >= EXP_MAX_S) begin
            final_res = inf_res(sign_q);
            final_ovf = 1'b1;
        end else if (rnd_exp <= ZERO_S) begin
            // No subnormal outputs: anything below the normal range flushes.
            final_res = {sign_q, {(DATA_W-1){1'b0}}};
            final_unf = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        take_special = 1'b0;
        do_norm      = 1'b0;
        do_round     = 1'b0;
        fire_done    = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_MULT: begin
                if (special_any) begin
                    take_special = 1'b1;
                    state_d      = ST_DONE;
                end else if (mul_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                do_norm = 1'b1;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                do_round = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                fire_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new start discards whatever is in flight, including a pending done.
        if (bus.start_i) begin
            state_d      = ST_MULT;
            take_special = 1'b0;
            do_norm      = 1'b0;
            do_round     = 1'b0;
            fire_done    = 1'b0;
        end
    end

    // ---------------- datapath ----------------
    // NOTE: datapath registers are reset too; the block is small and a known
    // value after reset keeps the flushed outputs free of X.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            exc_q    <= 1'b0;
        end else if (bus.start_i) begin
            op_a_q <= bus.op_a_i;
            op_b_q <= bus.op_b_i;
            sign_q <= bus.op_a_i[DATA_W-1] ^ bus.op_b_i[DATA_W-1];
            exp_q  <= exp_sum;
        end else if (take_special) begin
            res_q <= special_res;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            exc_q <= special_exc;
        end else if (do_norm) begin
            man_q    <= norm_man;
            guard_q  <= norm_g;
            round_q  <= norm_r;
            sticky_q <= norm_s;
            exp_q    <= exp_q + $signed({{(EW-1){1'b0}}, norm_inc});
        end else if (do_round) begin
            res_q <= final_res;
            ovf_q <= final_ovf;
            unf_q <= final_unf;
            exc_q <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            bus.done_o      <= 1'b0;
            bus.res_o       <= '0;
            bus.overflow_o  <= 1'b0;
            bus.underflow_o <= 1'b0;
            bus.exception_o <= 1'b0;
        end else begin
            bus.done_o <= fire_done;
            if (fire_done) begin
                bus.res_o       <= res_q;
                bus.overflow_o  <= ovf_q;
                bus.underflow_o <= unf_q;
                bus.exception_o <= exc_q;
            end
        end
    end

endmodule

// File: tb/tb_iob_fp_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_iob_fp_mul_seq
// Directed-vector bench for iob_fp_mul_seq (FP32). Expected results, flags
// ({overflow, underflow, exception}) and latencies are hand-computed.
// -----------------------------------------------------------------------------
module tb_iob_fp_mul_seq;

    localparam int LAT_NORMAL  = 27;
    localparam int LAT_SPECIAL = 2;
    localparam int WAIT_BUDGET = 60;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    logic clk_i    = 1'b0;
    logic arst_n_i = 1'b1;

    always #5 clk_i = ~clk_i;

    iob_fp_mul_seq_if #(.DATA_W(32)) bus ();

    iob_fp_mul_seq #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // done pulses counted away from the active edge
    always @(negedge clk_i) begin
        if (bus.done_o === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {29'd0, bus.overflow_o, bus.underflow_o, bus.exception_o};
    endfunction

    // Start pulse spans exactly one rising edge (the sampling edge).
    task automatic issue_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        bus.op_a_i  = a;
        bus.op_b_i  = b;
        bus.start_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Number of rising edges after the start edge until done_o is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= WAIT_BUDGET; n++) begin
            @(posedge clk_i);
            #1;
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue_start(v.a, v.b);
        wait_done(lat);
        check({v.tag, " latency"}, 32'(lat), 32'(v.lat));
        check({v.tag, " res"},     bus.res_o, v.res);
        check({v.tag, " flags"},   flags_now(), {29'd0, v.flags});
        @(posedge clk_i);
        #1;
        check({v.tag, " done width"}, {31'd0, bus.done_o}, 32'd0);
        check({v.tag, " res hold"}, bus.res_o, v.res);
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        int cnt0;

        vecs[0] = '{"2.0*3.0",    32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, LAT_NORMAL};
        vecs[1] = '{"1.5*1.5",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, LAT_NORMAL};
        vecs[2] = '{"sticky",     32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, LAT_NORMAL};
        vecs[3] = '{"sign",       32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 3'b000, LAT_NORMAL};
        vecs[4] = '{"overflow",   32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, LAT_NORMAL};
        vecs[5] = '{"underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010, LAT_NORMAL};
        vecs[6] = '{"inf*zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, LAT_SPECIAL};

        bus.start_i = 1'b0;
        bus.op_a_i  = '0;
        bus.op_b_i  = '0;

        // reset
        #2 arst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset res",   bus.res_o, 32'h0);
        check("reset flags", flags_now(), 32'h0);
        check("reset done",  {31'd0, bus.done_o}, 32'd0);
        @(negedge clk_i);
        arst_n_i = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // restart at cycle 10: only the second result appears
        cnt0 = done_cnt;
        issue_start(32'h4000_0000, 32'h4040_0000);
        repeat (9) @(posedge clk_i);
        issue_start(32'h3FC0_0000, 32'h3FC0_0000);
        wait_done(lat);
        check("restart latency", 32'(lat), 32'(LAT_NORMAL));
        check("restart res", bus.res_o, 32'h4010_0000);
        @(posedge clk_i);
        #1;
        check("restart done count", 32'(done_cnt - cnt0), 32'd1);

        // reset mid-MULT: outputs cleared, no done afterwards
        cnt0 = done_cnt;
        issue_start(32'h4000_0000, 32'h4040_0000);
        repeat (8) @(posedge clk_i);
        #3;
        arst_n_i = 1'b0;
        #1;
        check("abort res",   bus.res_o, 32'h0);
        check("abort flags", flags_now(), 32'h0);
        check("abort done",  {31'd0, bus.done_o}, 32'd0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        check("abort no done", 32'(done_cnt - cnt0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
